// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch unit: PC, imem req/ack fetch, IR and field decode.
// R-type words are folded so op_out carries funct.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        pc_en,
  input  logic        branch_sel,
  input  logic [1:0]  pc_src,
  input  logic [31:0] rs_data,
  output logic [5:0]  op_out,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] imm_sext,
  output logic [25:0] jaddr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        illegal_op
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic [31:0] next_pc;
  logic        op_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  if (imem_ack) state_d = S_HOLD;
      S_HOLD:  if (pc_en) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    req_d = 1'b0;
    ir_d  = ir_q;
    pc_d  = pc_q;
    unique case (state_q)
      S_FETCH: req_d = 1'b1;
      S_WAIT: begin
        req_d = ~imem_ack;
        if (imem_ack) ir_d = imem_rdata;
      end
      S_HOLD:  if (pc_en) pc_d = next_pc;
      default: req_d = 1'b0;
    endcase
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm16    = ir_q[15:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jaddr    = ir_q[25:0];
  assign op_out   = (ir_q[31:26] == 6'd0) ? ir_q[5:0]
                                          : ir_q[31:26];

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      2'b00: if (branch_sel)
               next_pc = pc_plus4 + (imm_sext << 2);
      2'b01: next_pc = {pc_plus4[31:28], jaddr, 2'b00};
      2'b10: next_pc = rs_data & 32'hFFFF_FFFC;
      default: next_pc = pc_plus4;
    endcase
  end

  // Opcode and funct codes share one command space after folding.
  always_comb begin
    op_ok = 1'b0;
    unique case (op_out)
      6'b100011, 6'b101011, 6'b000010,
      6'b000011, 6'b000101, 6'b001110,
      6'b001001, 6'b100000, 6'b100010,
      6'b101010, 6'b001000: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign illegal_op  = instr_valid & ~op_ok;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
// Randomized bench for instr_fetch_unit against a
// behavioural PC/IR reference model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        pc_en;
  logic        branch_sel;
  logic [1:0]  pc_src;
  logic [31:0] rs_data;
  logic [5:0]  op_out;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] imm_sext;
  logic [25:0] jaddr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        illegal_op;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;

  logic [5:0] sup_codes [11] = '{
    6'b100011, 6'b101011, 6'b000010, 6'b000011,
    6'b000101, 6'b001110, 6'b001001, 6'b100000,
    6'b100010, 6'b101010, 6'b001000
  };

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc_en(pc_en), .branch_sel(branch_sel),
    .pc_src(pc_src), .rs_data(rs_data),
    .op_out(op_out), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .imm_sext(imm_sext),
    .jaddr(jaddr), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] model_op(input logic [31:0] w);
    if (w[31:26] == 6'd0) return w[5:0];
    return w[31:26];
  endfunction

  function automatic bit model_ok(input logic [5:0] op);
    foreach (sup_codes[i])
      if (sup_codes[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_decode;
    logic [31:0] sx;
    sx = 32'(int'($signed(m_ir[15:0])));
    check_eq("op_out", 32'(op_out), 32'(model_op(m_ir)));
    check_eq("rs", 32'(rs), m_ir >> 21 & 32'h1F);
    check_eq("rt", 32'(rt), m_ir >> 16 & 32'h1F);
    check_eq("rd", 32'(rd), m_ir >> 11 & 32'h1F);
    check_eq("imm16", 32'(imm16), m_ir & 32'hFFFF);
    check_eq("imm_sext", imm_sext, sx);
    check_eq("jaddr", 32'(jaddr), m_ir & 32'h03FF_FFFF);
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("valid", 32'(instr_valid), 32'd1);
    check_eq("req_low", 32'(imem_req), 32'd0);
    check_eq("illegal", 32'(illegal_op),
             32'(!model_ok(model_op(m_ir))));
  endtask

  task automatic wait_req;
    int n = 0;
    while (!imem_req && n < 8) begin
      step;
      n++;
    end
    check_eq("req_rise", 32'(imem_req), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] w,
                       input int d,
                       input bit noise);
    wait_req;
    check_eq("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < d - 1; i++) begin
      pc_en = noise & 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step;
      pc_en = 1'b0;
      check_eq("wait_req", 32'(imem_req), 32'd1);
      check_eq("wait_addr", imem_addr, m_pc);
      check_eq("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    pc_en = noise;
    step;
    imem_ack = 1'b0;
    pc_en = 1'b0;
    m_ir = w;
    check_decode;
    if (noise) begin
      imem_ack = 1'b1;
      imem_rdata = ~w;
      step;
      imem_ack = 1'b0;
      check_decode;
    end
  endtask

  task automatic advance(input logic [1:0] src,
                         input logic br,
                         input logic [31:0] rsv);
    logic [31:0] p4, exp;
    p4 = m_pc + 32'd4;
    case (src)
      2'd0: exp = br ? p4 + 32'(int'($signed(m_ir[15:0])) * 4) : p4;
      2'd1: exp = (p4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
      2'd2: exp = rsv & ~32'd3;
      default: exp = p4;
    endcase
    pc_src = src;
    branch_sel = br;
    rs_data = rsv;
    pc_en = 1'b1;
    step;
    pc_en = 1'b0;
    m_pc = exp;
    check_eq("adv_valid", 32'(instr_valid), 32'd0);
    check_eq("adv_pc", pc, exp);
  endtask

  function automatic logic [31:0] rand_word;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return {6'd0, r[25:6], sup_codes[$urandom_range(7, 10)]};
      1: return {sup_codes[$urandom_range(0, 6)], r[25:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    pc_en = 1'b0;
    branch_sel = 1'b0;
    pc_src = 2'b00;
    rs_data = '0;
    m_pc = 32'h0;
    m_ir = 32'h0;
    #12;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_illegal", 32'(illegal_op), 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_op", 32'(op_out), 32'd0);
    step;
    rst_n = 1'b1;

    fetch(32'h8C22_0004, 3, 1'b0);
    check_eq("lw_op", 32'(op_out), 32'h23);
    check_eq("lw_imm", imm_sext, 32'd4);
    advance(2'b10, 1'b0, 32'h0000_0013);

    fetch(32'h1400_FFFF, 1, 1'b1);
    advance(2'b00, 1'b1, 32'h0);
    check_eq("br_back", pc, 32'h10);
    fetch(32'h1400_FFFF, 2, 1'b0);
    advance(2'b00, 1'b0, 32'h0);
    check_eq("br_nt", pc, 32'h14);

    fetch(32'h0022_1820, 2, 1'b1);
    check_eq("add_op", 32'(op_out), 32'h20);
    check_eq("add_rd", 32'(rd), 32'd3);
    advance(2'b11, 1'b0, 32'h0);
    fetch(32'h0000_003F, 1, 1'b0);
    check_eq("illegal_3f", 32'(illegal_op), 32'd1);
    advance(2'b10, 1'b0, 32'h1000_0000);

    fetch(32'h0800_0040, 4, 1'b1);
    advance(2'b01, 1'b0, 32'h0);
    check_eq("jump", pc, 32'h1000_0100);
    fetch(32'h0800_0040, 1, 1'b0);
    advance(2'b10, 1'b0, 32'h0000_0207);
    check_eq("jr", pc, 32'h0000_0204);

    fetch(32'h8C22_0004, 1, 1'b0);
    advance(2'b10, 1'b0, 32'hFFFF_FFFF);
    fetch(32'h0022_1820, 1, 1'b0);
    advance(2'b11, 1'b0, 32'h0);
    check_eq("wrap", pc, 32'h0);

    for (int n = 0; n < 40; n++) begin
      fetch(rand_word(), $urandom_range(1, 4),
            1'($urandom_range(0, 1)));
      advance(2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom);
    end

    wait_req;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(imem_req), 32'd0);
    check_eq("mid_rst_pc", pc, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step;
    rst_n = 1'b1;
    step;
    imem_ack = 1'b0;
    m_pc = 32'h0;
    check_eq("post_rst_req", 32'(imem_req), 32'd1);
    check_eq("post_rst_addr", imem_addr, 32'h0);
    check_eq("post_rst_valid", 32'(instr_valid), 32'd0);
    check_eq("post_rst_imm", 32'(imm16), 32'd0);
    fetch(32'hAC22_0008, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
